uart_tx_arb: RTL
================

# uart_tx_arb

Frame scheduler and arbiter sitting in front of the single `uart_tx` serializer. It accepts bytes from up to four requesters (for example, CPU MMIO write path and debug printf port) over valid/ready handshakes and grants one at a time. It drives `uart_tx`'s `din`/`tx_start`/`lcr` and holds them stable for the whole frame, because `uart_tx` reads `din` and `lcr[0]` live during DATA. It also inserts an optional idle gap, counted in `tick_16x` periods, between consecutive frames.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `GAP_TICKS`, default 0: idle gap after each frame in `tick_16x` pulses, 0..255; 0 means no gap.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `tick_16x`  in  1  16x baud strobe, same signal that feeds `uart_tx`
- `enable`  in  1  when 0, no new requests are accepted; an in-flight frame completes
- `lcr_cfg`  in  3  `{stop_bits, parity_type, parity_en}` for the next frame; latched at accept
- `req_valid`  in  NREQ  per-requester byte valid
- `req_data`  in  8*NREQ  byte i is at `[8i+7:8i]`
- `req_ready`  out  NREQ  one-hot accept strobe
- `utx_din`  out  8  to `uart_tx.din`
- `utx_start`  out  1  to `uart_tx.tx_start`
- `utx_lcr`  out  3  to `uart_tx.lcr`
- `utx_busy`  in  1  from `uart_tx.tx_busy`
- `utx_done`  in  1  from `uart_tx.tx_done` (1-clk pulse)
- `busy`  out  1  high from accept until return to IDLE (gap included)
- `frame_done`  out  1  1-clk pulse per completed frame
- `done_id`  out  2  requester index of the frame reported by `frame_done`

## Operation
- The FSM has four states: IDLE, START, WAIT_DONE, GAP.
- **IDLE:**
  - If `enable`=1 and any `req_valid`=1, the arbiter selects grant g and drives `req_ready[g]`=1 combinationally in that cycle.
  - The byte, `lcr_cfg` and g are registered into `utx_din`, `utx_lcr` and the active id. The state moves to START.
  - `req_ready` is 0 in every other state, when `enable`=0, and while `rst_n`=0.
- **START:**
  - `utx_start`=1 is held until `utx_busy` is sampled 1. The state then moves to WAIT_DONE and `utx_start` drops.
  - No timeout is applied, since `uart_tx` samples `tx_start` only on a `tick_16x` in its IDLE.
- **WAIT_DONE:**
  - On `utx_done`=1: `frame_done` pulses and `done_id` is set to the active id (both registered, in the next cycle).
  - The state then moves to GAP if `GAP_TICKS`>0, otherwise to IDLE.
- **GAP:** an 8-bit counter increments on each `tick_16x`. When it reaches `GAP_TICKS`, the state moves to IDLE and the counter clears.
- **Arbitration:**
  - Round-robin with a last-grant pointer; the search starts at pointer+1, modulo NREQ.
  - The pointer updates only on accept. Its reset value is NREQ-1, so requester 0 wins first.
- **Stability:** `utx_din` and `utx_lcr` change only on accept and are stable from START through WAIT_DONE.
- **Requester drops `req_valid` before accept:** no effect, nothing is captured.
- **`utx_done` outside WAIT_DONE:** ignored.
- **`enable` dropped mid-frame:** the frame and gap finish, then the block stays in IDLE.
- **Reset, including mid-frame:** state IDLE, `utx_start`=0, `utx_din`=0, `utx_lcr`=0, `busy`=0, `frame_done`=0, `done_id`=0, pointer=NREQ-1, gap counter=0.

## Timing
- **Accept to start:** if accept occurs in cycle N, `utx_start`=1 from N+1.
- **Start to `uart_tx` IDLE exit:** `uart_tx` leaves its IDLE on the first `tick_16x` at or after N+1.
- **`utx_start` deassertion:** `utx_start` deasserts the cycle after `utx_busy` is seen high, at most 1 extra cycle of overlap.
- **Frame completion:** `frame_done` is asserted in cycle M+1 when `utx_done` occurs in cycle M.
- **Re-accept after a frame:** with `GAP_TICKS`=0, the next accept can occur in cycle M+1 at the earliest, so one byte per frame time.
- **`busy`:** goes to 1 in N+1 and to 0 in the cycle the state returns to IDLE.

## Configuration
- **`UART_TX_ARB_PRIO_EN` defined:** fixed priority; the lowest index with `req_valid` always wins, and the pointer is unused.
- **Not defined:** round-robin as described under Operation.

## Test plan
- **Single byte, NREQ=2, `GAP_TICKS`=0:** `req_valid[0]`=1, data 0x55, `lcr_cfg`=3'b011 -> `req_ready[0]` pulses once, `utx_din`=0x55 and `utx_lcr`=3'b011 stable until `utx_done`, `frame_done` with `done_id`=0, `busy` back to 0.
- **Contention:** both valid continuously, data0=0xA0, data1=0xB1 -> frame order 0,1,0,1 with each `done_id` matching. With `UART_TX_ARB_PRIO_EN` defined, order is 0,0,0,0.
- **Gap:** `GAP_TICKS`=20, back-to-back requests -> exactly 20 `tick_16x` pulses between `frame_done` and the next `req_ready`.
- **Enable:** `enable` dropped during frame 1 with a request pending -> frame 1 completes, no further `req_ready`. Re-asserting `enable` resumes acceptance.
- **Reset mid-frame:** `rst_n` pulsed low during DATA of byte 0x3C -> all outputs at reset values immediately. After release, the first grant goes to requester 0.
- **Withdrawn request:** `req_valid[1]` pulsed while the block is in WAIT_DONE and dropped before the frame ends -> no accept for requester 1, no extra frame.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester-side valid/ready bundle for uart_tx_arb.
// Byte i of req_data sits at [8i+7:8i].
interface uart_tx_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates requester bytes into the single uart_tx serializer.
// Define UART_TX_ARB_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_arb #(
  parameter int NREQ      = 2,
  parameter int GAP_TICKS = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_16x,
  input  logic         enable,
  input  logic [2:0]   lcr_cfg,
  uart_tx_arb_if.slave req,
  output logic [7:0]   utx_din,
  output logic         utx_start,
  output logic [2:0]   utx_lcr,
  input  logic         utx_busy,
  input  logic         utx_done,
  output logic         busy,
  output logic         frame_done,
  output logic [1:0]   done_id
);

  localparam logic [7:0] GAP_LAST =
    8'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [7:0] din_q, din_d;
  logic [2:0] lcr_q, lcr_d;
  logic [1:0] id_q, id_d;
  logic [1:0] did_q, did_d;
  logic       fd_q, fd_d;
  logic [7:0] gap_q, gap_d;

  logic [3:0]      vld;
  logic [7:0]      byte_w [4];
  logic [1:0]      gnt;
  logic            accept;
  logic [NREQ-1:0] rdy;

  // Widen to four slots so a 2-bit grant always indexes legally.
  assign vld = 4'(req.req_valid);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    if (i < NREQ) begin : g_on
      assign byte_w[i] = req.req_data[8*i +: 8];
    end else begin : g_off
      assign byte_w[i] = '0;
    end
  end

`ifdef UART_TX_ARB_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (vld[2'(k)]) gnt = 2'(k);
    end
  end
`else
  logic [1:0] ptr_q;

  always_comb begin
    logic       hit;
    logic [1:0] c;
    gnt = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = 2'((int'(ptr_q) + k) % NREQ);
      if (!hit && vld[c]) begin
        gnt = c;
        hit = 1'b1;
      end
    end
  end

  // Pointer moves only on accept; reset value makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'(NREQ - 1);
    end else if (accept) begin
      ptr_q <= gnt;
    end
  end
`endif

  assign accept = rst_n && enable &&
                  (state_q == S_IDLE) && (|vld);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rdy[i] = accept && (gnt == 2'(i));
    end
  end

  assign req.req_ready = rdy;

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    lcr_d   = lcr_q;
    id_d    = id_q;
    did_d   = did_q;
    fd_d    = 1'b0;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          din_d   = byte_w[gnt];
          lcr_d   = lcr_cfg;
          id_d    = gnt;
          state_d = S_START;
        end
      end
      S_START: begin
        if (utx_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (utx_done) begin
          fd_d    = 1'b1;
          did_d   = id_q;
          state_d = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (tick_16x) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      din_q   <= '0;
      lcr_q   <= '0;
      id_q    <= '0;
      did_q   <= '0;
      fd_q    <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      lcr_q   <= lcr_d;
      id_q    <= id_d;
      did_q   <= did_d;
      fd_q    <= fd_d;
      gap_q   <= gap_d;
    end
  end

  // uart_tx reads din/lcr live, so they come straight from held registers.
  assign utx_din    = din_q;
  assign utx_lcr    = lcr_q;
  assign utx_start  = (state_q == S_START);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = fd_q;
  assign done_id    = did_q;

endmodule
